fifo32_buf: RTL
===============

Name: fifo32_buf

Overview:
- Synchronous FIFO of 32-bit words. Buffers the stream a producer writes so the downstream 32-bit register stage can consume it at its own pace.
- The write side accepts one word per cycle. The read side presents one registered word per pop.
- Provides full/empty/count status plus overflow/underflow sticky flags for debug on the Mojo board.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH_LOG2, 3, log2 of entry count (default 8 entries).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- R  input  1  reset, asynchronous, active-high.
- in  input  WIDTH  write data.
- wr_en  input  1  push request.
- rd_en  input  1  pop request.
- out  output  WIDTH  registered read data.
- out_valid  output  1  one-cycle pulse: out updated by a pop this cycle.
- full  output  1  count == 2**DEPTH_LOG2.
- empty  output  1  count == 0.
- count  output  DEPTH_LOG2+1  number of stored words.
- ovf  output  1  sticky: push attempted while full.
- unf  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (R=1, asynchronous, takes effect without a clock edge). While R is held, every edge is ignored.
  - Pointers cleared, count=0.
  - out=32'h00000000, out_valid=0, empty=1, full=0, ovf=0, unf=0.
  - Storage array contents are not reset and are don't-care.
- Reset mid-operation discards all stored words immediately.
- First edge after R deasserts behaves normally.
- Push accepted = wr_en & (~full | rd_en_accepted).
  - Writes in to mem[wr_ptr], then wr_ptr increments modulo depth.
- Pop accepted = rd_en & ~empty.
  - out <= mem[rd_ptr] at the edge, out_valid=1 for the following cycle, rd_ptr increments modulo depth.
  - Read latency is 1 cycle: data appears on out the cycle after rd_en is sampled.
- out holds its last popped value when no pop occurs. out_valid=0 in any cycle without an accepted pop.
- Simultaneous push and pop:
  - Not full, not empty: both happen, count unchanged.
  - Full: pop frees a slot, so the push is accepted; count stays at depth.
  - Empty: pop rejected (unf set), push accepted, count becomes 1. No write-through bypass: the word is readable starting next cycle.
- Rejected push (full, no pop): data dropped, ovf <= 1, state otherwise unchanged.
- Rejected pop (empty): out unchanged, out_valid=0, unf <= 1.
- ovf/unf clear only on reset.
- Pointers are DEPTH_LOG2 bits and wrap naturally (7 -> 0 for the default depth).
- count is maintained as an explicit counter: +1 on push-only, -1 on pop-only.
- full and empty are combinational decodes of count.

Decomposition:
- Shared package/header: WIDTH default, DEPTH_LOG2 default, reset value of out (32'h0).
- One sub-module, fifo_ptr: DEPTH_LOG2-bit wrap-around pointer with inc enable and asynchronous active-high reset. Instantiated twice (wr and rd).
- Storage array, count and flag logic live in fifo32_buf.

Test Plan:
- Reset:
  - Stimulus: assert R mid-stream, between clock edges.
  - Response: out=0, empty=1, count=0 immediately.
  - Stimulus: after release, pop.
  - Response: unf=1, out stays 0.
- Ordering:
  - Stimulus: push EEEEEEEE, EE0E5EA0, EEEE5EEE, then pop 3 times.
  - Response: out sequence EEEEEEEE, EE0E5EA0, EEEE5EEE, each with out_valid=1 one cycle after its rd_en; empty=1 after the third pop.
- Full/overflow:
  - Stimulus: push 8 words 0AB00000..0AB00007.
  - Response: full=1, count=8.
  - Stimulus: push 9th word D0D020E0.
  - Response: ovf=1, count=8.
  - Stimulus: drain all 8.
  - Response: 0AB00000..0AB00007 returned; D0D020E0 never appears.
- Simultaneous at full:
  - Stimulus: with 8 entries stored, wr_en=rd_en=1 with in=100200E5.
  - Response: oldest word out, count stays 8.
  - Stimulus: subsequent drain.
  - Response: 100200E5 is the last word returned.
- Wrap-around:
  - Stimulus: 20 alternating push/pop pairs with data 09005E00+i.
  - Response: every popped word equals its push, count never exceeds 1, pointers wrap past 7 with no corruption.
- Empty push+pop:
  - Stimulus: with the FIFO empty, wr_en=rd_en=1 with in=0607A061.
  - Response: unf=1, count=1, out unchanged.
  - Stimulus: next-cycle pop.
  - Response: out=0607A061.

Source files
------------

// File: rtl/fifo32_buf_pkg.sv
// Shared defaults for the 32-bit FIFO buffer: geometry, read-data reset value
// and the per-cycle operation encoding used by the count logic.
package fifo32_buf_pkg;

    localparam int          WIDTH_DEF      = 32;
    localparam int          DEPTH_LOG2_DEF = 3;
    localparam logic [31:0] OUT_RST        = 32'h0000_0000;

    // Accepted operation for one cycle, {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo32_buf_ptr.sv
// Wrap-around FIFO pointer: W-bit register that advances by one when inc_i is
// high and rolls over naturally at 2**W.
module fifo_ptr #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q, ptr_d;

    assign ptr_d = inc_i ? ptr_q + W'(1) : ptr_q;
    assign ptr_o = ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fifo32_buf.sv
// Synchronous FIFO of WIDTH-bit words with a registered read port, explicit
// occupancy counter, and sticky overflow/underflow debug flags.
module fifo32_buf
    import fifo32_buf_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic [WIDTH-1:0]      in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf,
    output logic                  unf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;

    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [WIDTH-1:0]      out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  push, pop;
    fifo_op_e              op;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    // A pop frees a slot in the same edge, so a full FIFO can still take a push.
    assign pop  = rd_en & ~empty;
    assign push = wr_en & (~full | pop);
    assign op   = fifo_op_e'({push, pop});

    fifo_ptr #(.W(DEPTH_LOG2)) u_wr_ptr (
        .clk_i (clk),
        .rst_i (R),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.W(DEPTH_LOG2)) u_rd_ptr (
        .clk_i (clk),
        .rst_i (R),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        case (op)
            OP_PUSH: count_d = count_q + 1'b1;
            OP_POP:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = pop;
        if (pop) begin
            out_d = mem_q[rd_ptr];
        end
        ovf_d = ovf_q | (wr_en & ~push);
        unf_d = unf_q | (rd_en & empty);
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            count_q     <= '0;
            out_q       <= WIDTH'(OUT_RST);
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage is never reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push && !R) begin
            mem_q[wr_ptr] <= in;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule
